// File: rtl/halftone_frame_sequencer.sv
// Frame sequencer around the 8x6 halftone pixel-processor array: loads 48 raster
// pixels, waits for the array's error ripple to settle, then streams six row bytes.
module halftone_frame_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int N_PIX         = 48,
    parameter int N_ROWS        = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] pixel_1,  pixel_2,  pixel_3,  pixel_4,  pixel_5,  pixel_6,  pixel_7,  pixel_8,
    output logic [7:0] pixel_9,  pixel_10, pixel_11, pixel_12, pixel_13, pixel_14, pixel_15, pixel_16,
    output logic [7:0] pixel_17, pixel_18, pixel_19, pixel_20, pixel_21, pixel_22, pixel_23, pixel_24,
    output logic [7:0] pixel_25, pixel_26, pixel_27, pixel_28, pixel_29, pixel_30, pixel_31, pixel_32,
    output logic [7:0] pixel_33, pixel_34, pixel_35, pixel_36, pixel_37, pixel_38, pixel_39, pixel_40,
    output logic [7:0] pixel_41, pixel_42, pixel_43, pixel_44, pixel_45, pixel_46, pixel_47, pixel_48,
    input  logic [1:8] HTPV_Row_1,
    input  logic [1:8] HTPV_Row_2,
    input  logic [1:8] HTPV_Row_3,
    input  logic [1:8] HTPV_Row_4,
    input  logic [1:8] HTPV_Row_5,
    input  logic [1:8] HTPV_Row_6,
    output logic [7:0] htpv_byte,
    output logic       htpv_valid,
    input  logic       htpv_ready,
    output logic       row_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    localparam logic [5:0] PIX_LAST    = 6'(N_PIX - 1);
    localparam logic [2:0] ROW_LAST    = 3'(N_ROWS - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_r, state_s;
    logic [5:0]  pix_idx_r;
    logic [3:0]  settle_cnt_r;
    logic [2:0]  row_idx_r;
    logic [7:0]  pix_mem_r [0:N_PIX-1];
    logic [7:0]  row_cap_r [0:N_ROWS-1];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and output decode; outputs depend on registered state only
    always_comb begin
        state_s    = state_r;
        pix_ready  = 1'b0;
        busy       = 1'b0;
        htpv_valid = 1'b0;
        htpv_byte  = 8'h00;
        row_last   = 1'b0;
        case (state_r)
            ST_LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid && (pix_idx_r == PIX_LAST)) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_EMIT: begin
                busy       = 1'b1;
                htpv_valid = 1'b1;
                htpv_byte  = row_cap_r[row_idx_r];
                row_last   = (row_idx_r == ROW_LAST);
                if (htpv_ready && (row_idx_r == ROW_LAST)) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

    // Frame assembly, settle timing, row capture and row indexing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_idx_r    <= 6'd0;
            settle_cnt_r <= 4'd0;
            row_idx_r    <= 3'd0;
            for (int i = 0; i < N_PIX; i++) pix_mem_r[i] <= 8'h00;
            for (int r = 0; r < N_ROWS; r++) row_cap_r[r] <= 8'h00;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (pix_valid) begin
                        pix_mem_r[pix_idx_r] <= pix_in;
                        if (pix_idx_r == PIX_LAST) begin
                            pix_idx_r    <= 6'd0;
                            settle_cnt_r <= 4'd0;
                        end else begin
                            pix_idx_r <= pix_idx_r + 6'd1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        // Leftmost array column lands in bit 7 of each row byte
                        row_cap_r[0] <= HTPV_Row_1;
                        row_cap_r[1] <= HTPV_Row_2;
                        row_cap_r[2] <= HTPV_Row_3;
                        row_cap_r[3] <= HTPV_Row_4;
                        row_cap_r[4] <= HTPV_Row_5;
                        row_cap_r[5] <= HTPV_Row_6;
                        row_idx_r    <= 3'd0;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 4'd1;
                    end
                end
                ST_EMIT: begin
                    if (htpv_ready) begin
                        if (row_idx_r == ROW_LAST) begin
                            row_idx_r <= 3'd0;
                        end else begin
                            row_idx_r <= row_idx_r + 3'd1;
                        end
                    end
                end
                default: begin
                    row_idx_r <= 3'd0;
                end
            endcase
        end
    end

    assign pixel_1  = pix_mem_r[0];  assign pixel_2  = pix_mem_r[1];  assign pixel_3  = pix_mem_r[2];  assign pixel_4  = pix_mem_r[3];
    assign pixel_5  = pix_mem_r[4];  assign pixel_6  = pix_mem_r[5];  assign pixel_7  = pix_mem_r[6];  assign pixel_8  = pix_mem_r[7];
    assign pixel_9  = pix_mem_r[8];  assign pixel_10 = pix_mem_r[9];  assign pixel_11 = pix_mem_r[10]; assign pixel_12 = pix_mem_r[11];
    assign pixel_13 = pix_mem_r[12]; assign pixel_14 = pix_mem_r[13]; assign pixel_15 = pix_mem_r[14]; assign pixel_16 = pix_mem_r[15];
    assign pixel_17 = pix_mem_r[16]; assign pixel_18 = pix_mem_r[17]; assign pixel_19 = pix_mem_r[18]; assign pixel_20 = pix_mem_r[19];
    assign pixel_21 = pix_mem_r[20]; assign pixel_22 = pix_mem_r[21]; assign pixel_23 = pix_mem_r[22]; assign pixel_24 = pix_mem_r[23];
    assign pixel_25 = pix_mem_r[24]; assign pixel_26 = pix_mem_r[25]; assign pixel_27 = pix_mem_r[26]; assign pixel_28 = pix_mem_r[27];
    assign pixel_29 = pix_mem_r[28]; assign pixel_30 = pix_mem_r[29]; assign pixel_31 = pix_mem_r[30]; assign pixel_32 = pix_mem_r[31];
    assign pixel_33 = pix_mem_r[32]; assign pixel_34 = pix_mem_r[33]; assign pixel_35 = pix_mem_r[34]; assign pixel_36 = pix_mem_r[35];
    assign pixel_37 = pix_mem_r[36]; assign pixel_38 = pix_mem_r[37]; assign pixel_39 = pix_mem_r[38]; assign pixel_40 = pix_mem_r[39];
    assign pixel_41 = pix_mem_r[40]; assign pixel_42 = pix_mem_r[41]; assign pixel_43 = pix_mem_r[42]; assign pixel_44 = pix_mem_r[43];
    assign pixel_45 = pix_mem_r[44]; assign pixel_46 = pix_mem_r[45]; assign pixel_47 = pix_mem_r[46]; assign pixel_48 = pix_mem_r[47];

endmodule

// File: doc/halftone_frame_sequencer.md
Name: halftone_frame_sequencer

Overview:
- Sequencing stage wrapped around the combinational 8x6 pixel-processor array.
- Upstream: accepts a raster-order stream of 8-bit grey pixels over a valid/ready handshake and assembles one 48-pixel frame in registers, which drive the array's pixel_1..pixel_48 inputs.
- Waits a programmable settle time for the array's long error-ripple path, then captures HTPV_Row_1..HTPV_Row_6.
- Downstream: emits the six halftone rows as bytes over a second valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 4, cycles spent in SETTLE before capturing rows (legal range 1..15).
- N_PIX, 48, pixels per frame (fixed by the 8x6 array; not to be overridden).
- N_ROWS, 6, rows per frame (fixed).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pix_in  input  8  incoming grey pixel, raster order, row 1 col 1 first.
- pix_valid  input  1  pix_in is valid this cycle.
- pix_ready  output  1  block accepts a pixel this cycle.
- pixel_1 .. pixel_48  output  8 each  frame registers driving the converter array.
- HTPV_Row_1 .. HTPV_Row_6  input  [1:8] each  halftone rows returned by the converter array.
- htpv_byte  output  8  current halftone row; bit7 = HTPV_Row_k[1] (leftmost), bit0 = HTPV_Row_k[8].
- htpv_valid  output  1  htpv_byte is valid.
- htpv_ready  input  1  downstream accepts htpv_byte.
- row_last  output  1  high with htpv_valid while row 6 is presented.
- busy  output  1  high in SETTLE and EMIT.

Behaviour:
- Reset (async, active-high): state=LOAD; pix_idx=0; settle_cnt=0; row_idx=0; pixel_1..48=0; row capture registers=0; pix_ready=1; htpv_valid=0; htpv_byte=0; row_last=0; busy=0.
- Accept/transfer rule: a pixel is accepted on a rising edge with pix_valid&&pix_ready. A byte transfers on a rising edge with htpv_valid&&htpv_ready.
- LOAD:
  - pix_ready=1, busy=0.
  - On accept, pixel_(pix_idx+1)<=pix_in and pix_idx increments (6-bit).
  - On the accept with pix_idx==47: pix_idx<=0, settle_cnt<=0, go to SETTLE.
  - pix_valid low inserts gaps; there is no timeout.
- SETTLE:
  - pix_ready=0, busy=1; pixel registers are frozen.
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES-1: capture all six HTPV rows into internal registers, row_idx<=0, go to EMIT.
- EMIT:
  - htpv_valid=1, htpv_byte=captured row (row_idx+1), row_last=(row_idx==5), pix_ready=0, busy=1.
  - On transfer: row_idx increments. If row_idx==5, go to LOAD (htpv_valid=0 next cycle).
  - htpv_byte is held stable while htpv_ready=0.
  - htpv_valid never drops before the transfer.
- Pixel registers are not cleared between frames; they are overwritten as the next frame loads. This is harmless because outputs are captured only in SETTLE.
- Minimum frame period: 48 + SETTLE_CYCLES + 6 cycles with no stalls.
- Outputs htpv_valid, htpv_byte, row_last, pix_ready and busy are registered, or decoded from state and registers only. No combinational path from pix_valid or htpv_ready to any output.
- Reset asserted mid-LOAD/SETTLE/EMIT: all state returns to reset values immediately. The partial frame is discarded and no further bytes are emitted.
- pix_valid asserted outside LOAD is ignored (pix_ready=0); the upstream source must hold the data.
- Counters never wrap past their terminal values: pix_idx max 47, row_idx max 5.

Test Plan:
- Reset, then stream 48 pixels of 0x00 back-to-back with htpv_ready=1 -> pix_ready falls after the 48th accept. Six bytes 0x00 then appear on consecutive cycles starting SETTLE_CYCLES cycles later; row_last is high on the 6th only; pix_ready returns the cycle after.
- 48 pixels of 0xFF -> six bytes 0xFF.
- Frame with pixel_1=0xFF and all others 0x00 -> first byte has bit7=1.
- Toggle pix_valid every other cycle -> exactly 48 accepts before SETTLE. pixel_k equals the k-th accepted value for k=1..48.
- Hold htpv_ready=0 for 5 cycles during EMIT of row 3 -> htpv_byte and htpv_valid stay stable. Row 4 follows only after the transfer; no byte is lost or duplicated.
- Assert reset after 20 pixels, release, then send a full 0xFF frame -> outputs are at reset values during reset. The next emitted frame is six 0xFF bytes.
- Two frames back-to-back with no stalls -> second frame's first byte appears exactly 48+SETTLE_CYCLES+6 cycles after the first frame's first byte.
